// File: rtl/ifetch_ctrl_if.sv
// Instruction-bus and decode-handoff signals of the fetch stage.
// The master modport is the fetch sequencer; the slave side is the bus plus decode.
interface ifetch_ctrl_if #(
    parameter int PC_W = 32
);
    logic            inst_req;
    logic            inst_addr_ok;
    logic            inst_data_ok;
    logic [31:0]     inst_rdata;
    logic            if_valid;
    logic            id_allowin;
    logic [31:0]     if_inst;
    logic [PC_W-1:0] if_pc;
    logic            if_adel;

    modport master (
        output inst_req,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata,
        output if_valid,
        output if_inst,
        output if_pc,
        output if_adel,
        input  id_allowin
    );

    modport slave (
        input  inst_req,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata,
        input  if_valid,
        input  if_inst,
        input  if_pc,
        input  if_adel,
        output id_allowin
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Fetch-stage sequencer: one outstanding instruction request, redirect cancellation,
// and a registered handoff of the fetched word to decode.
module ifetch_ctrl #(
    parameter int BOOT_DELAY = 4,
    parameter int PC_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [PC_W-1:0]  fetch_pc,
    input  logic             pc_adel,
    output logic             pc_refresh,
    input  logic             redirect,
    output logic             redirect_ack,
    ifetch_ctrl_if.master    bus
);

    localparam int CNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_DELAY - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  boot_cnt_r;
    logic [CNT_W-1:0]  boot_cnt_nxt_s;
    logic              cancel_r;
    logic              cancel_nxt_s;
    logic [PC_W-1:0]   pc_hold_r;
    logic [PC_W-1:0]   pc_hold_nxt_s;
    logic              if_valid_r;
    logic              if_valid_nxt_s;
    logic [31:0]       if_inst_r;
    logic [31:0]       if_inst_nxt_s;
    logic [PC_W-1:0]   if_pc_r;
    logic [PC_W-1:0]   if_pc_nxt_s;
    logic              if_adel_r;
    logic              if_adel_nxt_s;
    logic              inst_req_s;
    logic              redirect_ack_s;
    logic              seq_adv_s;

    // Next-state and handshake decode; redirect always wins over the other events of a state.
    always_comb begin
        state_nxt_s    = state_r;
        boot_cnt_nxt_s = boot_cnt_r;
        cancel_nxt_s   = cancel_r;
        pc_hold_nxt_s  = pc_hold_r;
        if_valid_nxt_s = if_valid_r;
        if_inst_nxt_s  = if_inst_r;
        if_pc_nxt_s    = if_pc_r;
        if_adel_nxt_s  = if_adel_r;
        inst_req_s     = 1'b0;
        redirect_ack_s = 1'b0;
        case (state_r)
            ST_BOOT: begin
                if (boot_cnt_r == BOOT_LAST) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    boot_cnt_nxt_s = boot_cnt_r + CNT_W'(1);
                end
            end
            ST_REQ: begin
                inst_req_s = !pc_adel;
                if (redirect) begin
                    redirect_ack_s = 1'b1;
                    // An address accepted together with a redirect is for a dead PC.
                    if (inst_req_s && bus.inst_addr_ok) begin
                        state_nxt_s   = ST_WAIT;
                        cancel_nxt_s  = 1'b1;
                        pc_hold_nxt_s = fetch_pc;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end else if (pc_adel) begin
                    state_nxt_s    = ST_HOLD;
                    if_valid_nxt_s = 1'b1;
                    if_inst_nxt_s  = 32'h0000_0000;
                    if_adel_nxt_s  = 1'b1;
                    if_pc_nxt_s    = fetch_pc;
                end else if (bus.inst_addr_ok) begin
                    state_nxt_s   = ST_WAIT;
                    pc_hold_nxt_s = fetch_pc;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.inst_data_ok) begin
                    if (cancel_r || redirect) begin
                        redirect_ack_s = redirect;
                        cancel_nxt_s   = 1'b0;
                        state_nxt_s    = ST_REQ;
                    end else begin
                        if_inst_nxt_s  = bus.inst_rdata;
                        if_pc_nxt_s    = pc_hold_r;
                        if_adel_nxt_s  = 1'b0;
                        if_valid_nxt_s = 1'b1;
                        state_nxt_s    = ST_HOLD;
                    end
                end else if (redirect) begin
                    redirect_ack_s = 1'b1;
                    cancel_nxt_s   = 1'b1;
                    state_nxt_s    = ST_WAIT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    redirect_ack_s = 1'b1;
                    if_valid_nxt_s = 1'b0;
                    state_nxt_s    = ST_REQ;
                end else if (bus.id_allowin) begin
                    if_valid_nxt_s = 1'b0;
                    state_nxt_s    = ST_REQ;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // Sequential PC advance happens only when decode takes the held word without a redirect.
    assign seq_adv_s    = (state_r == ST_HOLD) && if_valid_r && bus.id_allowin && !redirect;
    assign pc_refresh   = redirect_ack_s | seq_adv_s;
    assign redirect_ack = redirect_ack_s;

    assign bus.inst_req = inst_req_s;
    assign bus.if_valid = if_valid_r;
    assign bus.if_inst  = if_inst_r;
    assign bus.if_pc    = if_pc_r;
    assign bus.if_adel  = if_adel_r;

    // State, boot counter, cancel flag and decode-facing registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_BOOT;
            boot_cnt_r <= '0;
            cancel_r   <= 1'b0;
            pc_hold_r  <= '0;
            if_valid_r <= 1'b0;
            if_inst_r  <= 32'h0000_0000;
            if_pc_r    <= '0;
            if_adel_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            boot_cnt_r <= boot_cnt_nxt_s;
            cancel_r   <= cancel_nxt_s;
            pc_hold_r  <= pc_hold_nxt_s;
            if_valid_r <= if_valid_nxt_s;
            if_inst_r  <= if_inst_nxt_s;
            if_pc_r    <= if_pc_nxt_s;
            if_adel_r  <= if_adel_nxt_s;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a queue holds the decode handoffs the bench expects,
// and every accepted handoff is popped and compared.
module tb_ifetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic [31:0] fetch_pc;
    logic        pc_adel;
    logic        pc_refresh;
    logic        redirect;
    logic        redirect_ack;

    int   vec_cnt;
    int   err_cnt;
    int   handoff_cnt;
    exp_t sb_q[$];

    ifetch_ctrl_if #(.PC_W(32)) bus ();

    ifetch_ctrl #(.BOOT_DELAY(4), .PC_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .fetch_pc     (fetch_pc),
        .pc_adel      (pc_adel),
        .pc_refresh   (pc_refresh),
        .redirect     (redirect),
        .redirect_ack (redirect_ack),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        e.adel = adel;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then score any handoff decode accepts this cycle.
    task automatic settle();
        exp_t e;
        #1;
        if (bus.if_valid && bus.id_allowin && !redirect) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("handoff_pc", bus.if_pc, e.pc);
                check("handoff_inst", bus.if_inst, e.inst);
                check("handoff_adel", bus.if_adel, e.adel);
                handoff_cnt++;
            end
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        handoff_cnt = 0;
        resetn = 1'b0;
        fetch_pc = 32'hbfc0_0000;
        pc_adel = 1'b0;
        redirect = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata = 32'h0000_0000;
        bus.id_allowin = 1'b0;

        // Reset: outputs quiet even with redirect and addr_ok asserted.
        tick();
        tick();
        redirect = 1'b1;
        bus.inst_addr_ok = 1'b1;
        settle();
        check("rst_if_valid", bus.if_valid, 64'd0);
        check("rst_if_inst", bus.if_inst, 64'd0);
        check("rst_if_pc", bus.if_pc, 64'd0);
        check("rst_if_adel", bus.if_adel, 64'd0);
        check("rst_inst_req", bus.inst_req, 64'd0);
        check("rst_pc_refresh", pc_refresh, 64'd0);
        check("rst_redirect_ack", redirect_ack, 64'd0);
        redirect = 1'b0;
        bus.inst_addr_ok = 1'b0;
        tick();
        resetn = 1'b1;

        // Boot: first request in cycle 4 after release; redirect ignored meanwhile.
        for (int k = 1; k <= 4; k++) begin
            tick();
            redirect = (k < 3);
            settle();
            check("boot_inst_req", bus.inst_req, 64'(k == 4));
            if (k < 3) check("boot_redirect_ack", redirect_ack, 64'd0);
        end

        // First fetch with zero-wait bus and immediate acceptance.
        bus.inst_addr_ok = 1'b1;
        push(32'hbfc0_0000, 32'h3c1d_0001, 1'b0);
        settle();
        check("req1_inst_req", bus.inst_req, 64'd1);
        check("req1_pc_refresh", pc_refresh, 64'd0);
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'h3c1d_0001;
        bus.id_allowin = 1'b1;
        settle();
        check("wait1_inst_req", bus.inst_req, 64'd0);
        tick();
        bus.inst_data_ok = 1'b0;
        settle();
        check("accept1_if_valid", bus.if_valid, 64'd1);
        check("accept1_pc_refresh", pc_refresh, 64'd1);
        tick();
        fetch_pc = 32'hbfc0_0004;
        bus.id_allowin = 1'b0;
        settle();
        check("after1_if_valid", bus.if_valid, 64'd0);
        check("after1_inst_req", bus.inst_req, 64'd1);
        check("after1_pc_refresh", pc_refresh, 64'd0);

        // Backpressure: five stalled cycles in HOLD, stray data_ok ignored.
        bus.inst_addr_ok = 1'b1;
        push(32'hbfc0_0004, 32'h2404_0005, 1'b0);
        settle();
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'h2404_0005;
        settle();
        tick();
        bus.inst_rdata = 32'hdead_beef;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin
                tick();
                bus.inst_data_ok = 1'b0;
            end
            settle();
            check("bp_if_valid", bus.if_valid, 64'd1);
            check("bp_if_inst", bus.if_inst, 64'h2404_0005);
            check("bp_if_pc", bus.if_pc, 64'hbfc0_0004);
            check("bp_pc_refresh", pc_refresh, 64'd0);
            check("bp_inst_req", bus.inst_req, 64'd0);
        end
        tick();
        bus.id_allowin = 1'b1;
        settle();
        check("bp_release_refresh", pc_refresh, 64'd1);
        tick();
        bus.id_allowin = 1'b0;
        fetch_pc = 32'hbfc0_0010;
        settle();
        check("bp_next_inst_req", bus.inst_req, 64'd1);
        check("bp_next_refresh", pc_refresh, 64'd0);

        // Redirect while waiting for data: returned word is discarded.
        bus.inst_addr_ok = 1'b1;
        settle();
        tick();
        bus.inst_addr_ok = 1'b0;
        redirect = 1'b1;
        settle();
        check("wredir_ack", redirect_ack, 64'd1);
        check("wredir_refresh", pc_refresh, 64'd1);
        tick();
        redirect = 1'b0;
        fetch_pc = 32'hbfc0_0380;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'h1111_1111;
        settle();
        check("wredir_ack_once", redirect_ack, 64'd0);
        check("wredir_refresh_once", pc_refresh, 64'd0);
        tick();
        bus.inst_data_ok = 1'b0;
        settle();
        check("wredir_discard", bus.if_valid, 64'd0);
        check("wredir_refetch", bus.inst_req, 64'd1);

        // Redirect in the same cycle the address is accepted.
        bus.inst_addr_ok = 1'b1;
        redirect = 1'b1;
        settle();
        check("rredir_ack", redirect_ack, 64'd1);
        check("rredir_refresh", pc_refresh, 64'd1);
        tick();
        bus.inst_addr_ok = 1'b0;
        redirect = 1'b0;
        fetch_pc = 32'hbfc0_0180;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'h2222_2222;
        settle();
        check("rredir_wait_req", bus.inst_req, 64'd0);
        check("rredir_ack_once", redirect_ack, 64'd0);
        tick();
        bus.inst_data_ok = 1'b0;
        settle();
        check("rredir_discard", bus.if_valid, 64'd0);
        check("rredir_refetch", bus.inst_req, 64'd1);

        // Redirect in HOLD beats id_allowin: the held word is flushed.
        bus.inst_addr_ok = 1'b1;
        push(32'hbfc0_0180, 32'h4080_6000, 1'b0);
        settle();
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata = 32'h4080_6000;
        settle();
        tick();
        bus.inst_data_ok = 1'b0;
        bus.id_allowin = 1'b1;
        redirect = 1'b1;
        settle();
        check("hredir_ack", redirect_ack, 64'd1);
        check("hredir_refresh", pc_refresh, 64'd1);
        check("hredir_if_valid", bus.if_valid, 64'd1);
        check("hredir_sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            check("hredir_if_pc", bus.if_pc, sb_q[0].pc);
            void'(sb_q.pop_front());
        end

        // Misaligned PC: no bus request, error word handed to decode.
        tick();
        redirect = 1'b0;
        bus.id_allowin = 1'b0;
        fetch_pc = 32'hbfc0_0002;
        pc_adel = 1'b1;
        settle();
        check("hredir_drop", bus.if_valid, 64'd0);
        check("adel_no_req", bus.inst_req, 64'd0);
        check("adel_no_refresh", pc_refresh, 64'd0);
        push(32'hbfc0_0002, 32'h0000_0000, 1'b1);
        tick();
        bus.id_allowin = 1'b1;
        settle();
        check("adel_if_valid", bus.if_valid, 64'd1);
        check("adel_refresh", pc_refresh, 64'd1);
        tick();
        pc_adel = 1'b0;
        bus.id_allowin = 1'b0;
        fetch_pc = 32'hbfc0_0380;
        settle();
        check("adel_next_req", bus.inst_req, 64'd1);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("handoff_count", 64'(handoff_cnt), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
